// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode fetch controller.
// Holds the screen geometry, the clear-engine fill code, the character
// buffer address width, the clear FSM state encoding and the cell address
// helper used by both the display and host paths.
package text_pkg;

  localparam int unsigned COLS      = 80;
  localparam int unsigned ROWS      = 60;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FONT_LAT  = 1;
  localparam logic [7:0]  FILL_CHAR = 8'h20;
  localparam int unsigned AW        = 13;
  localparam int unsigned CELLS     = COLS * ROWS;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  // row*80 + col as two shifts and adds; the multiplier is fixed at 80.
  function automatic logic [AW-1:0] cell_addr(input logic [6:0] col,
                                               input logic [5:0] row);
    logic [AW-1:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {6'd0, col};
  endfunction

endpackage

// File: rtl/text_fetch_ctrl_if.sv
// Host write bus into the character buffer.
//   wr_valid/wr_ready : request/accept handshake (accepted when both high)
//   wr_col/wr_row     : target cell
//   wr_data           : character code
//   wr_err            : one-cycle pulse after an accepted out-of-range write
interface text_fetch_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_err;

  modport master (
    output wr_valid, wr_col, wr_row, wr_data,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_data,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/text_ram.sv
// 4800x8 single-port synchronous character buffer, read-first with a
// registered read port so it maps onto block RAM. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : cell address
//   wdata_i : write data
//   rdata_o : data at addr_i from the previous cycle (old data on write)
module text_ram
  import text_pkg::*;
(
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [CELLS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/text_fetch_ctrl.sv
// Text-mode scheduler between vga_sync and the font ROM.
// Prefetches the next cell's code once per 8-pixel cell so `character` is
// valid in the same cycle as the pixel coordinate, shares the buffer's single
// port between display fetches, the clear engine and host writes (in that
// priority), and delays the sync flags by the font ROM latency.
//   px_clk, rst                 : clock, synchronous active-high reset
//   x_px, y_px, activevideo,
//   hsync_in, vsync_in          : raster from vga_sync
//   character                   : code of the current cell
//   active_d, hsync_d, vsync_d  : sync flags delayed FONT_LAT cycles
//   wr                          : host write bus
//   clr_req, busy               : screen clear request / engine running
module text_fetch_ctrl
  import text_pkg::*;
(
  input  logic               px_clk,
  input  logic               rst,
  input  logic [9:0]         x_px,
  input  logic [9:0]         y_px,
  input  logic               activevideo,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [7:0]         character,
  output logic               active_d,
  output logic               hsync_d,
  output logic               vsync_d,
  text_fetch_ctrl_if.slave   wr,
  input  logic               clr_req,
  output logic               busy
);

  localparam logic [9:0]    X_FETCH_END = 10'(H_ACTIVE - 8);
  localparam logic [9:0]    X_WRAP_F    = 10'(H_TOTAL - 2);
  localparam logic [9:0]    X_WRAP_T    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_ACT       = 10'(V_ACTIVE);
  localparam logic [AW-1:0] CNT_LAST    = AW'(CELLS - 1);
  localparam logic [6:0]    COL_LIM     = 7'(COLS);
  localparam logic [5:0]    ROW_LIM     = 6'(ROWS);

  // Fetch scheduling
  logic       fetch_cyc;
  logic [6:0] f_col;
  logic [5:0] f_row;
  logic [9:0] y_nx;

  always_comb begin
    y_nx      = y_px + 10'd1;
    fetch_cyc = 1'b0;
    f_col     = '0;
    f_row     = y_px[8:3];
    if (x_px[2:0] == 3'd6 && x_px < X_FETCH_END) begin
      fetch_cyc = 1'b1;
      f_col     = x_px[9:3] + 7'd1;
    end else if (x_px == X_WRAP_F) begin
      fetch_cyc = 1'b1;
      f_row     = (y_nx < Y_ACT) ? y_nx[8:3] : '0;
    end
  end

  // Host write handshake
  logic wr_hs, wr_ok;
  assign wr.wr_ready = !rst && !fetch_cyc && !busy;
  assign wr_hs       = wr.wr_valid && wr.wr_ready;
  assign wr_ok       = (wr.wr_col < COL_LIM) && (wr.wr_row < ROW_LIM);

  // Clear FSM
  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (!fetch_cyc) begin
          clr_we = 1'b1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // RAM port arbitration: display fetch > clear > host write
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cell_addr(wr.wr_col, wr.wr_row);
    ram_wdata = wr.wr_data;
    if (fetch_cyc) begin
      ram_addr = cell_addr(f_col, f_row);
    end else if (busy) begin
      ram_addr  = cnt_q;
      ram_wdata = FILL_CHAR;
      ram_we    = clr_we && !rst;
    end else begin
      ram_we = wr_hs && wr_ok;
    end
  end

  text_ram u_ram (
    .clk_i   (px_clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Character pipeline. The read result is taken straight off the RAM in the
  // cycle after the fetch so it can transfer to `character` on that same
  // phase-7 edge; next_char_q only keeps it for cycles that are not a
  // fetch return.
  logic       fetch_q;
  logic [7:0] next_char, next_char_q, char_q;
  logic       xfer;

  assign next_char = fetch_q ? ram_rdata : next_char_q;
  assign xfer      = (x_px[2:0] == 3'd7) || (x_px == X_WRAP_T);

  always_ff @(posedge px_clk) begin
    if (rst) begin
      fetch_q     <= 1'b0;
      next_char_q <= '0;
      char_q      <= '0;
    end else begin
      fetch_q     <= fetch_cyc;
      next_char_q <= next_char;
      if (xfer) char_q <= next_char;
    end
  end

  assign character = char_q;

  // Error pulse
  logic err_q;
  always_ff @(posedge px_clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= wr_hs && !wr_ok;
  end
  assign wr.wr_err = err_q;

  // Sync delay matching the font ROM latency
  logic [FONT_LAT-1:0] act_q, hs_q, vs_q;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      act_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      act_q[0] <= activevideo;
      hs_q[0]  <= hsync_in;
      vs_q[0]  <= vsync_in;
      for (int unsigned i = 1; i < FONT_LAT; i++) begin
        act_q[i] <= act_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  assign active_d = act_q[FONT_LAT-1];
  assign hsync_d  = hs_q[FONT_LAT-1];
  assign vsync_d  = vs_q[FONT_LAT-1];

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Bench for text_fetch_ctrl: reference model of buffer contents, clear
// engine and handshakes; display scan expectations go through a queue.
module tb_text_fetch_ctrl;
  import text_pkg::*;

  logic       px_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x_px = '0, y_px = '0;
  logic       activevideo = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0] character;
  logic       active_d, hsync_d, vsync_d;
  logic       clr_req = 1'b0;
  logic       busy;

  text_fetch_ctrl_if wif ();

  text_fetch_ctrl dut (
    .px_clk      (px_clk),
    .rst         (rst),
    .x_px        (x_px),
    .y_px        (y_px),
    .activevideo (activevideo),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .character   (character),
    .active_d    (active_d),
    .hsync_d     (hsync_d),
    .vsync_d     (vsync_d),
    .wr          (wif.slave),
    .clr_req     (clr_req),
    .busy        (busy)
  );

  always #5 px_clk = ~px_clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference state
  logic [7:0]  m_mem [CELLS];
  logic        m_busy = 1'b0;
  int unsigned m_cnt  = 0;
  logic        m_err  = 1'b0;
  logic        m_act = 1'b0, m_hs = 1'b0, m_vs = 1'b0;
  logic [7:0]  sb [$];
  logic        scan_en  = 1'b0;
  logic        last_hs  = 1'b0;
  logic        obs_busy = 1'b0;

  function automatic logic is_fetch(input int x);
    return ((x % 8) == 6 && x < 632) || x == 798;
  endfunction

  task automatic set_px(input int x, input int y);
    x_px        = 10'(x);
    y_px        = 10'(y);
    activevideo = (x < 640) && (y < 480);
    hsync_in    = 1'($urandom_range(0, 1));
    vsync_in    = 1'($urandom_range(0, 1));
  endtask

  // One pixel clock: compare at negedge, advance the model, cross posedge.
  task automatic step();
    logic f, rdy, hs, ok;
    logic [7:0] e;
    f   = is_fetch(int'(x_px));
    rdy = !rst && !f && !m_busy;
    hs  = wif.wr_valid && rdy;
    ok  = (wif.wr_col < 80) && (wif.wr_row < 60);
    if (scan_en && activevideo)
      sb.push_back(m_mem[int'(y_px >> 3) * COLS + int'(x_px >> 3)]);
    @(negedge px_clk);
    check_eq("busy", busy, m_busy);
    check_eq("wr_ready", wif.wr_ready, rdy);
    check_eq("wr_err", wif.wr_err, m_err);
    check_eq("active_d", active_d, m_act);
    check_eq("hsync_d", hsync_d, m_hs);
    check_eq("vsync_d", vsync_d, m_vs);
    if (scan_en && activevideo) begin
      if (sb.size() == 0) check_eq("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check_eq("character", character, e);
      end
    end
    obs_busy = busy;
    last_hs  = hs;
    if (rst) begin
      m_busy = 1'b0; m_err = 1'b0;
      m_act = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
    end else begin
      m_err = hs && !ok;
      if (hs && ok) m_mem[int'(wif.wr_row) * COLS + int'(wif.wr_col)] = wif.wr_data;
      if (!m_busy) begin
        if (clr_req) begin m_busy = 1'b1; m_cnt = 0; end
      end else if (!f) begin
        m_mem[m_cnt] = FILL_CHAR;
        if (m_cnt == CELLS - 1) m_busy = 1'b0;
        else m_cnt++;
      end
      m_act = activevideo; m_hs = hsync_in; m_vs = vsync_in;
    end
    @(posedge px_clk);
    #1;
  endtask

  task automatic hwrite(input int col, input int row, input logic [7:0] d,
                        input int x0);
    bit acc;
    acc = 1'b0;
    wif.wr_valid = 1'b1;
    wif.wr_col   = 7'(col);
    wif.wr_row   = 6'(row);
    wif.wr_data  = d;
    for (int i = 0; i < 16 && !acc; i++) begin
      set_px(x0 + i, 500);
      step();
      acc = last_hs;
    end
    wif.wr_valid = 1'b0;
    if (!acc) check_eq("wr_timeout", 1, 0);
    set_px(700, 500);
    step();
  endtask

  task automatic scan_row(input int r);
    int k, y, yp;
    k  = (r % 3 == 1) ? 0 : r % 8;
    y  = r * 8 + k;
    yp = (y == 0) ? 479 : y - 1;
    scan_en = 1'b1;
    set_px(798, yp); step();
    set_px(799, yp); step();
    for (int x = 0; x < 640; x++) begin
      set_px(x, y);
      step();
    end
    scan_en = 1'b0;
  endtask

  initial begin
    int unsigned cnt, fch;
    int          xc;
    bit          seen, done;

    for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h00;
    wif.wr_valid = 1'b0;
    wif.wr_col   = '0;
    wif.wr_row   = '0;
    wif.wr_data  = '0;

    // Reset
    @(posedge px_clk); #1;
    for (int i = 0; i < 3; i++) begin set_px(100 + i, 0); step(); end
    check_eq("rst_character", character, 0);
    rst = 1'b0;

    // Full clear with an out-of-range write held pending throughout
    wif.wr_valid = 1'b1; wif.wr_col = 7'd80; wif.wr_row = 6'd5; wif.wr_data = 8'h99;
    xc = 0;
    clr_req = 1'b1; set_px(xc, 0); step(); clr_req = 1'b0;
    cnt = 0; fch = 0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      xc = (xc + 1) % 800;
      set_px(xc, 0);
      step();
      if (obs_busy) begin
        seen = 1'b1;
        cnt++;
        if (is_fetch(xc)) fch++;
      end else if (seen) done = 1'b1;
    end
    wif.wr_valid = 1'b0;
    check_eq("clr_done", done, 1);
    check_eq("clr_cycles", cnt, CELLS + fch);
    set_px(700, 500); step();

    // Host writes, including range boundaries
    hwrite(0, 0, 8'h41, 700);
    hwrite(1, 0, 8'h42, 700);
    hwrite(0, 1, 8'h55, 700);
    hwrite(79, 59, 8'h33, 700);
    hwrite(80, 5, 8'h99, 700);
    hwrite(0, 60, 8'h98, 700);
    // Offered at a fetch cycle: refused at x=6, accepted at x=7
    hwrite(3, 2, 8'h7E, 6);

    for (int r = 0; r < ROWS; r++) scan_row(r);

    // Reset in the middle of a clear
    clr_req = 1'b1; set_px(100, 0); step(); clr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin set_px(101 + i, 0); step(); end
    check_eq("busy_before_rst", obs_busy, 1);
    rst = 1'b1;
    set_px(122, 0); hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_char", character, 0);
    check_eq("rst_mid_act", active_d, 0);
    check_eq("rst_mid_hs", hsync_d, 0);
    check_eq("rst_mid_vs", vsync_d, 0);
    rst = 1'b0;
    set_px(700, 500); step();

    // Restarted clear must begin at address 0
    hwrite(0, 0, 8'h41, 700);
    hwrite(4, 0, 8'h44, 700);
    clr_req = 1'b1; set_px(700, 500); step(); clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin set_px(701 + i, 500); step(); end
    rst = 1'b1; set_px(704, 500); step();
    rst = 1'b0; set_px(705, 500); step();
    scan_row(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_fetch_ctrl.md
Name: text_fetch_ctrl

Overview:
Text-mode scheduler between vga_sync and the font ROM. Owns an 80x60 character buffer (one byte per 8x8 cell). Once per cell it prefetches the next cell's code, so `character` is valid in the same cycle as the pixel coordinate. It shares the buffer's single RAM port between display fetches, host writes and a screen-clear engine, and delays the sync signals to match the font ROM latency.

Parameters:
COLS, 80, character columns (H_ACTIVE/8)
ROWS, 60, character rows (V_ACTIVE/8)
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, pixels per line including blanking
V_ACTIVE, 480, visible lines
FONT_LAT, 1, font ROM read latency in px_clk cycles
FILL_CHAR, 8'h20, code written by the clear engine

Ports:
px_clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
x_px  in  10  current pixel column from vga_sync
y_px  in  10  current pixel line from vga_sync
activevideo  in  1  active-video flag from vga_sync
hsync_in  in  1  hsync from vga_sync
vsync_in  in  1  vsync from vga_sync
character  out  8  code of cell (x_px>>3, y_px>>3); drives font.character
active_d  out  1  activevideo delayed FONT_LAT cycles
hsync_d  out  1  hsync_in delayed FONT_LAT cycles
vsync_d  out  1  vsync_in delayed FONT_LAT cycles
wr_valid  in  1  host write request
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
wr_col  in  7  target column
wr_row  in  6  target row
wr_data  in  8  character code
wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
clr_req  in  1  start screen clear (level sampled)
busy  out  1  clear engine running

Behaviour:
- Reset:
  - character=0; active_d, hsync_d, vsync_d=0; wr_err=0; busy=0.
  - Clear FSM goes to IDLE; wr_ready=0 while rst is high.
  - RAM contents are not reset.
- Address: addr = row*COLS + col, 13 bits. Computed as (row<<6)+(row<<4)+col for COLS=80.
- Fetch cycles (fetch_cyc):
  - x_px[2:0]==6 and x_px < H_ACTIVE-8: read (col=(x_px>>3)+1, row=y_px>>3).
  - x_px==H_TOTAL-2: read (col=0, row=next_row), where next_row=(y_px+1)>>3 if y_px+1 < V_ACTIVE, else 0.
- RAM read latency is 1 cycle. The result is latched into next_char on the following cycle (phase 7 or H_TOTAL-1).
- Transfer: character <= next_char when x_px[2:0]==7 or x_px==H_TOTAL-1. Otherwise character holds. The new code is therefore valid from the first pixel of each cell.
- Sync delay: active_d/hsync_d/vsync_d are FONT_LAT-deep shift registers of their inputs. Gate rgb with active_d.
- Port arbitration, fixed priority:
  - Display fetch (never stalled) > clear engine > host write.
  - wr_ready = !rst && !fetch_cyc && !busy.
- Host write:
  - On handshake with wr_col<COLS and wr_row<ROWS, RAM is written that cycle.
  - If out of range, no RAM write and wr_err=1 next cycle.
  - A write to the cell being displayed takes effect at that cell's next fetch (no bypass).
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR; busy=1 from the next cycle; counter=0. clr_req while busy is ignored.
  - CLEAR: on each non-fetch cycle, write FILL_CHAR at counter and increment. On fetch cycles, hold.
  - After writing address COLS*ROWS-1 -> IDLE; busy=0 the cycle after that write.
  - rst mid-clear -> IDLE immediately. Partially cleared RAM is acceptable.
- A simultaneous clr_req and wr_valid handshake in IDLE: the write completes, then the clear starts and overwrites it.
- Inputs are assumed coherent. x_px >= H_TOTAL never occurs, and no fetch is defined for it.

Decomposition:
- Package text_pkg:
  - COLS, ROWS, H_ACTIVE, H_TOTAL, V_ACTIVE, FILL_CHAR, address width (13).
  - Clear FSM state encoding (IDLE, CLEAR).
- One sub-module, text_ram: 4800x8 single-port synchronous RAM (read-first, registered read). It maps to BRAM.
- Arbitration, fetch scheduling, the clear FSM and the sync delay stay in text_fetch_ctrl.

Test Plan:
- Preload cells (0,0)=0x41 and (1,0)=0x42, then run a line at y_px=0 -> character=0x41 for x_px 0..7 and 0x42 for x_px 8..15. A RAM read fires only at x_px=6, 14, ... and 798.
- Line wrap: cell (0,1)=0x55, y_px=7 reaching x_px=798 -> character=0x55 at x_px=0 of line y_px=8. At y_px=479, the wrap fetches row 0.
- Hold wr_valid with (3,2,0x7E) across x_px=6 -> wr_ready=0 at x_px=6, write accepted at x_px=7. Display of (3,2) shows 0x7E on the next frame.
- Write wr_col=80, wr_row=5 -> handshake completes, wr_err pulses one cycle, RAM unchanged (read back via display).
- Pulse clr_req -> busy high; wr_ready=0 throughout; all 4800 cells = 0x20 afterwards. busy drops after exactly 4800 plus fetch-cycle-count cycles.
- Assert rst during CLEAR -> busy=0, character=0 and all delayed outputs=0 the next cycle. A new clr_req then restarts at address 0.
